// File: rtl/vx_schedule_pkg.sv
// Shared types for the schedule arbiter/buffer: the schedule payload and its width helpers.
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif

package vx_schedule_pkg;

  localparam int unsigned UUID_WIDTH    = 44;
  localparam int unsigned NW_WIDTH      = 2;
  localparam int unsigned SCHED_TMASK_W = `NUM_THREADS;
  localparam int unsigned XLEN          = 32;

  typedef struct packed {
    logic [UUID_WIDTH-1:0]    uuid;
    logic [NW_WIDTH-1:0]      wid;
    logic [SCHED_TMASK_W-1:0] tmask;
    logic [XLEN-1:0]          PC;
  } sched_data_t;

  localparam int unsigned SCHED_DATA_W = $bits(sched_data_t);

  // Index width that stays at least one bit for a single requester.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer, pointer moves past
// the winner whenever the caller strobes advance.
module vx_rr_arbiter #(
  parameter int unsigned NUM_REQS = 2,
  localparam int unsigned IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] requests,
  input  logic                advance,
  output logic                grant_valid,
  output logic [IDX_W-1:0]    grant_index,
  output logic [NUM_REQS-1:0] grant_onehot
);

  logic [IDX_W-1:0] ptr_q;

  // Scan from the farthest candidate down so the closest one to the pointer wins.
  always_comb begin
    int idx;
    idx          = 0;
    grant_valid  = 1'b0;
    grant_index  = '0;
    grant_onehot = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % NUM_REQS;
      if (requests[idx]) begin
        grant_valid       = 1'b1;
        grant_index       = IDX_W'(idx);
        grant_onehot      = '0;
        grant_onehot[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= (grant_index == IDX_W'(NUM_REQS - 1)) ? '0 : grant_index + 1'b1;
    end
  end

endmodule

// File: rtl/vx_schedule_arb_buf.sv
// Merges NUM_INPUTS schedule requesters round-robin into a DEPTH-entry FIFO with flush and
// source tagging. Optional perf counters under VX_SCHED_PERF_EN (tied to 0 otherwise).
module vx_schedule_arb_buf
  import vx_schedule_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned THREAD_CNT = `NUM_THREADS,
  localparam int unsigned SEL_W = sel_width(NUM_INPUTS)
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_INPUTS-1:0]                in_valid,
  input  logic [NUM_INPUTS*SCHED_DATA_W-1:0]   in_data,
  output logic [NUM_INPUTS-1:0]                in_ready,
  output logic                                 out_valid,
  output logic [SCHED_DATA_W-1:0]              out_data,
  output logic [SEL_W-1:0]                     out_sel,
  input  logic                                 out_ready,
  output logic [31:0]                          perf_stalls,
  output logic [31:0]                          perf_issued
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if (THREAD_CNT != SCHED_TMASK_W) begin : g_bad_tmask
    $error("THREAD_CNT must match the packed tmask width of sched_data_t");
  end

  logic [SCHED_DATA_W-1:0] mem_q [DEPTH];
  logic [SEL_W-1:0]        sel_mem_q [DEPTH];
  logic [AW-1:0]           rd_q, wr_q;
  logic [CW-1:0]           count_q;

  logic                    grant_valid;
  logic [SEL_W-1:0]        grant_index;
  logic [NUM_INPUTS-1:0]   grant_onehot;
  logic                    pop, push, space, accept_en;
  logic [SCHED_DATA_W-1:0] push_data;

  vx_rr_arbiter #(
    .NUM_REQS (NUM_INPUTS)
  ) u_arb (
    .clk          (clk),
    .reset        (reset),
    .requests     (in_valid),
    .advance      (push),
    .grant_valid  (grant_valid),
    .grant_index  (grant_index),
    .grant_onehot (grant_onehot)
  );

  always_comb begin
    out_valid = (count_q != '0);
    pop       = out_valid && out_ready;
    space     = (count_q < CW'(DEPTH)) || pop;
    accept_en = space && !flush && !reset;
    in_ready  = grant_onehot & {NUM_INPUTS{accept_en}};
    push      = grant_valid && accept_en;
    push_data = in_data[int'(grant_index)*SCHED_DATA_W +: SCHED_DATA_W];
    // Masked so an empty or freshly reset FIFO presents zeros rather than stale storage.
    out_data  = out_valid ? mem_q[rd_q] : '0;
    out_sel   = out_valid ? sel_mem_q[rd_q] : '0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q]     <= push_data;
      sel_mem_q[wr_q] <= grant_index;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef VX_SCHED_PERF_EN
  logic [31:0] stalls_q, issued_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stalls_q <= '0;
      issued_q <= '0;
    end else begin
      if (|in_valid && !push) stalls_q <= stalls_q + 32'd1;
      if (pop)                issued_q <= issued_q + 32'd1;
    end
  end

  assign perf_stalls = stalls_q;
  assign perf_issued = issued_q;
`else
  assign perf_stalls = '0;
  assign perf_issued = '0;
`endif

endmodule

// File: tb/tb_vx_schedule_arb_buf.sv
// Self-checking bench: queue-based reference model compared every cycle, plus directed checks.
module tb_vx_schedule_arb_buf;
  import vx_schedule_pkg::*;

  localparam int N     = 2;
  localparam int D     = 4;
  localparam int W     = SCHED_DATA_W;
  localparam int SEL_W = sel_width(N);

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic [N-1:0]     in_valid = '0;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_ready = 1'b0;
  logic [31:0]      perf_stalls, perf_issued;

  logic [W-1:0] src_data [N];

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = src_data[i];
  end

  vx_schedule_arb_buf #(
    .NUM_INPUTS (N),
    .DEPTH      (D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sel     (out_sel),
    .out_ready   (out_ready),
    .perf_stalls (perf_stalls),
    .perf_issued (perf_issued)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an ordered list of buffered entries plus a round-robin start index.
  logic [W-1:0]     mq_data [$];
  logic [SEL_W-1:0] mq_sel  [$];
  int               m_rr = 0;
  logic [31:0]      m_stalls = 0;
  logic [31:0]      m_issued = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      int           g;
      bit           sp, has_head, do_push, do_pop;
      logic [N-1:0] exp_ir;
      g = -1;
      for (int k = N - 1; k >= 0; k--) if (in_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
      has_head = (mq_data.size() != 0);
      sp       = (mq_data.size() < D) || (has_head && out_ready);
      exp_ir   = '0;
      if (g >= 0 && sp && !flush && !reset) exp_ir[g] = 1'b1;

      chk("in_ready", in_ready, exp_ir);
      chk("out_valid", out_valid, has_head);
      chk("out_data", out_data, has_head ? mq_data[0] : '0);
      chk("out_sel", out_sel, has_head ? mq_sel[0] : '0);
`ifdef VX_SCHED_PERF_EN
      chk("perf_stalls", perf_stalls, m_stalls);
      chk("perf_issued", perf_issued, m_issued);
`else
      chk("perf_stalls", perf_stalls, 0);
      chk("perf_issued", perf_issued, 0);
`endif

      if (reset) begin
        mq_data.delete();
        mq_sel.delete();
        m_rr = 0;
        m_stalls = 0;
        m_issued = 0;
      end else begin
        do_pop  = has_head && out_ready;
        do_push = (g >= 0) && exp_ir[g];
        if (do_pop) begin
          void'(mq_data.pop_front());
          void'(mq_sel.pop_front());
          m_issued++;
        end
        if (|in_valid && !do_push) m_stalls++;
        if (flush) begin
          mq_data.delete();
          mq_sel.delete();
        end else if (do_push) begin
          mq_data.push_back(in_data[g*W +: W]);
          mq_sel.push_back(SEL_W'(g));
          m_rr = (g + 1) % N;
        end
      end
    end
  end

  function automatic logic [W-1:0] rand_data();
    return W'({$urandom, $urandom, $urandom});
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_valid = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    sched_data_t  lit;
    logic [N-1:0] acc;
    int           n_acc;
    int           seq [$];

    src_data[0] = '0;
    src_data[1] = '0;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;

    // Single push on source 0, visible one cycle later, then popped.
    lit.uuid  = 44'h123;
    lit.wid   = 2'd1;
    lit.tmask = 'hF;
    lit.PC    = 32'h8000_0000;
    src_data[0] = lit;
    in_valid = 2'b01;
    #1 chk("t1_ready", in_ready, 2'b01);
    tick();
    in_valid = '0;
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, {44'h123, 2'd1, 4'hF, 32'h8000_0000});
    chk("t1_sel", out_sel, 0);
    out_ready = 1'b1;
    tick();
    chk("t1_empty", out_valid, 1'b0);

    // Both sources valid continuously: grants must alternate starting at 0.
    do_reset();
    src_data[0] = rand_data();
    src_data[1] = rand_data();
    in_valid = 2'b11;
    out_ready = 1'b1;
    repeat (10) begin
      tick();
      if (out_valid) seq.push_back(int'(out_sel));
    end
    in_valid = '0;
    chk("t2_len", (seq.size() >= 8), 1'b1);
    for (int i = 0; i < 8 && i < seq.size(); i++) chk("t2_alt", seq[i], i % 2);

    // Backpressure: 6 offers into a 4-deep FIFO.
    do_reset();
    src_data[0] = rand_data();
    in_valid = 2'b01;
    n_acc = 0;
    repeat (6) begin
      #1 if (in_ready[0]) n_acc++;
      tick();
    end
    chk("t3_accepted", n_acc, 4);
    #1 chk("t3_full_ready", in_ready, 2'b00);
`ifdef VX_SCHED_PERF_EN
    chk("t3_stalls", perf_stalls, 2);
`endif
    out_ready = 1'b1;
    #1 chk("t3_pushpop_ready", in_ready, 2'b01);
    tick();
    chk("t3_still_valid", out_valid, 1'b1);
`ifdef VX_SCHED_PERF_EN
    chk("t3_issued", perf_issued, 1);
`endif
    in_valid = '0;
    out_ready = 1'b0;

    // Flush with 3 buffered entries: head popped, requester refused, rr pointer kept at 1.
    do_reset();
    src_data[0] = rand_data();
    in_valid = 2'b01;
    repeat (3) tick();
    flush = 1'b1;
    out_ready = 1'b1;
    #1 chk("t4_flush_ready", in_ready, 2'b00);
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    chk("t4_flushed", out_valid, 1'b0);
    in_valid = 2'b11;
    #1 chk("t4_rr_kept", in_ready, 2'b10);
    in_valid = '0;
    tick();

    // Reset with two entries buffered and nonzero counters.
    src_data[1] = rand_data();
    in_valid = 2'b10;
    repeat (2) tick();
    reset = 1'b1;
    #1 chk("t6_reset_ready", in_ready, 2'b00);
    tick();
    chk("t6_valid", out_valid, 1'b0);
    chk("t6_stalls", perf_stalls, 0);
    chk("t6_issued", perf_issued, 0);
    reset = 1'b0;
    #1 chk("t6_ready_after", in_ready, 2'b10);
    in_valid = '0;
    tick();

    // Random traffic with backpressure and occasional flush; model checks order across wrap.
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      #2 acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] || !in_valid[i]) begin
          in_valid[i] = ($urandom_range(0, 1) == 1);
          src_data[i] = rand_data();
        end
      end
    end
    in_valid = '0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("drained", out_valid, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
